// File: rtl/wombat_debug_pkg.sv
// Shared types for the wombat debug probe: probe mode encoding and its width.
// Pure declarations; no logic, no latency, no flow control.
package wombat_debug_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      LIVE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } probe_mode_t;

endpackage

// File: rtl/wombat_debug_probe_if.sv
// Probe bus: buttons, channel sources and trigger in; selected value, index, mode and reset request out.
// The probe drives the slave side; the board/bench drives the master side.
interface wombat_debug_probe_if
   import wombat_debug_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int N_CHANNELS = 16
);
   logic [1:0]                    i_buttons;
   logic [WIDTH-1:0]              i_channels [N_CHANNELS];
   logic                          i_trigger;
   logic [WIDTH-1:0]              o_out;
   logic [$clog2(N_CHANNELS)-1:0] o_sel;
   logic [MODE_W-1:0]             o_mode;
   logic                          o_reset;

   modport master (
      output i_buttons, i_channels, i_trigger,
      input  o_out, o_sel, o_mode, o_reset
   );

   modport slave (
      input  i_buttons, i_channels, i_trigger,
      output o_out, o_sel, o_mode, o_reset
   );
endinterface

// File: rtl/wombat_debounce.sv
// Button conditioner: 2-flop synchroniser plus debounce; level moves after CYCLES stable cycles.
// rise is a one-cycle pulse registered together with the level's rising edge; no backpressure.
module wombat_debounce #(
   parameter int CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise
);
   localparam int CW = $clog2(CYCLES + 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
         rise   <= 1'b0;
      end else begin
         sync_a <= din;
         sync_b <= sync_a;
         rise   <= 1'b0;
         // Any cycle agreeing with the current level restarts the qualification window.
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CW'(CYCLES - 1)) begin
            cnt   <= '0;
            level <= sync_b;
            rise  <= sync_b;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/wombat_debug_probe.sv
// Debug probe: STEP/MODE buttons pick a channel and LIVE/HOLD(/SCAN) mode; o_out registered, 1-cycle latency.
// No backpressure. SCAN mode and its dwell counter exist only when WOMBAT_DEBUG_PROBE_SCAN_EN is defined.
module wombat_debug_probe
   import wombat_debug_pkg::*;
#(
   parameter int WIDTH             = 8,
   parameter int N_CHANNELS        = 16,
   parameter int DEBOUNCE_CYCLES   = 1024,
   parameter int SCAN_CYCLES       = 50_000_000,
   parameter int RESET_HOLD_CYCLES = 100_000_000,
   parameter int ACTIVE_LOW        = 1
) (
   input logic           clk,
   input logic           i_reset,
   wombat_debug_probe_if.slave bus
);
   localparam int SW = $clog2(N_CHANNELS);
   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);

   logic [1:0]       lvl;
   logic [1:0]       rise;
   logic             both;
   logic             step_evt;
   logic             mode_evt;
   probe_mode_t      mode;
   probe_mode_t      next_mode;
   logic [SW-1:0]    sel;
   logic [SW-1:0]    sel_inc;
   logic [WIDTH-1:0] snap [N_CHANNELS];
   logic [WIDTH-1:0] sel_val;
   logic [WIDTH-1:0] out_r;
   logic [HW-1:0]    hold_cnt;
   logic             hold_fired;
   logic             reset_r;

   wombat_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step (
      .clk(clk), .rst(i_reset), .din(bus.i_buttons[0]), .level(lvl[0]), .rise(rise[0])
   );

   wombat_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_mode (
      .clk(clk), .rst(i_reset), .din(bus.i_buttons[1]), .level(lvl[1]), .rise(rise[1])
   );

   // Holding both buttons is the reset gesture, so neither counts as a press.
   assign both     = lvl[0] & lvl[1];
   assign step_evt = rise[0] & ~both;
   assign mode_evt = rise[1] & ~both;
   assign sel_inc  = (sel == SW'(N_CHANNELS - 1)) ? '0 : sel + 1'b1;
   assign sel_val  = (mode == HOLD) ? snap[sel] : bus.i_channels[sel];

   always_comb begin
      next_mode = LIVE;
`ifdef WOMBAT_DEBUG_PROBE_SCAN_EN
      case (mode)
         LIVE:    next_mode = HOLD;
         HOLD:    next_mode = SCAN;
         default: next_mode = LIVE;
      endcase
`else
      next_mode = (mode == LIVE) ? HOLD : LIVE;
`endif
   end

`ifdef WOMBAT_DEBUG_PROBE_SCAN_EN
   localparam int DW = $clog2(SCAN_CYCLES + 1);
   logic [DW-1:0] dwell;
`endif

   always_ff @(posedge clk) begin
      if (i_reset) begin
         mode       <= LIVE;
         sel        <= '0;
         out_r      <= (ACTIVE_LOW != 0) ? '1 : '0;
         reset_r    <= 1'b0;
         hold_cnt   <= '0;
         hold_fired <= 1'b0;
         for (int i = 0; i < N_CHANNELS; i++) snap[i] <= '0;
`ifdef WOMBAT_DEBUG_PROBE_SCAN_EN
         dwell      <= '0;
`endif
      end else begin
         out_r   <= (ACTIVE_LOW != 0) ? ~sel_val : sel_val;
         reset_r <= 1'b0;

         // One request per hold; re-armed only once both buttons are back up.
         if (both) begin
            if (!hold_fired) begin
               if (hold_cnt == HW'(RESET_HOLD_CYCLES - 1)) begin
                  reset_r    <= 1'b1;
                  hold_fired <= 1'b1;
                  hold_cnt   <= '0;
               end else begin
                  hold_cnt <= hold_cnt + 1'b1;
               end
            end
         end else begin
            hold_cnt <= '0;
            if (lvl == 2'b00) hold_fired <= 1'b0;
         end

         if (mode_evt) mode <= next_mode;

         // Entry takes priority; a trigger in the entry cycle is ignored since mode is not yet HOLD.
         if ((mode_evt && next_mode == HOLD) || (mode == HOLD && bus.i_trigger))
            snap <= bus.i_channels;

`ifdef WOMBAT_DEBUG_PROBE_SCAN_EN
         if (mode == SCAN) begin
            if (step_evt || dwell == DW'(SCAN_CYCLES - 1)) begin
               sel   <= sel_inc;
               dwell <= '0;
            end else begin
               dwell <= dwell + 1'b1;
            end
         end else begin
            dwell <= '0;
            if (step_evt) sel <= sel_inc;
         end
`else
         if (step_evt) sel <= sel_inc;
`endif
      end
   end

   assign bus.o_out   = out_r;
   assign bus.o_sel   = sel;
   assign bus.o_mode  = mode;
   assign bus.o_reset = reset_r;
endmodule

// File: tb/tb_wombat_debug_probe.sv
// Directed bench for wombat_debug_probe: WIDTH=8, N=4, debounce 4, scan 8, reset hold 16, active-low.
module tb_wombat_debug_probe;
   logic clk = 1'b0;
   logic i_reset;
   int   checks   = 0;
   int   failures = 0;
   int   pulses;
   int   sel_before;
   int   mode_before;

   always #5 clk = ~clk;

   wombat_debug_probe_if #(.WIDTH(8), .N_CHANNELS(4)) bus ();

   wombat_debug_probe #(
      .WIDTH(8), .N_CHANNELS(4), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(8),
      .RESET_HOLD_CYCLES(16), .ACTIVE_LOW(1)
   ) dut (
      .clk(clk), .i_reset(i_reset), .bus(bus)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int b, input int hold);
      bus.i_buttons[b] = 1'b1;
      cyc(hold);
      bus.i_buttons[b] = 1'b0;
      cyc(10);
   endtask

   task automatic trig();
      bus.i_trigger = 1'b1;
      cyc(1);
      bus.i_trigger = 1'b0;
      cyc(1);
   endtask

   initial begin
      i_reset       = 1'b1;
      bus.i_buttons = 2'b00;
      bus.i_trigger = 1'b0;
      bus.i_channels[0] = 8'h11;
      bus.i_channels[1] = 8'h22;
      bus.i_channels[2] = 8'h33;
      bus.i_channels[3] = 8'h44;
      cyc(3);
      chk("rst_sel",   int'(bus.o_sel),   0);
      chk("rst_mode",  int'(bus.o_mode),  0);
      chk("rst_out",   int'(bus.o_out),   'hFF);
      chk("rst_reset", int'(bus.o_reset), 0);
      i_reset = 1'b0;
      cyc(1);
      chk("live_out_first", int'(bus.o_out), 'hEE);

      // A 3-cycle press is one short of qualifying.
      press(0, 3);
      chk("glitch_sel", int'(bus.o_sel), 0);
      press(0, 8); chk("step1", int'(bus.o_sel), 1);
      press(0, 8); chk("step2", int'(bus.o_sel), 2);
      press(0, 8); chk("step3", int'(bus.o_sel), 3);
      press(0, 8); chk("step_wrap", int'(bus.o_sel), 0);

      press(1, 8);
      chk("mode_hold", int'(bus.o_mode), 1);
      bus.i_channels[0] = 8'h55;
      cyc(2);
      chk("hold_frozen", int'(bus.o_out), 'hEE);
      trig();
      chk("hold_trig", int'(bus.o_out), 'hAA);
      press(0, 8);
      chk("hold_step_sel", int'(bus.o_sel), 1);
      chk("hold_step_out", int'(bus.o_out), 'hDD);

`ifdef WOMBAT_DEBUG_PROBE_SCAN_EN
      bus.i_buttons[1] = 1'b1;
      for (int i = 0; i < 20 && bus.o_mode != 2'd2; i++) cyc(1);
      chk("mode_scan", int'(bus.o_mode), 2);
      bus.i_buttons[1] = 1'b0;
      cyc(7); chk("dwell_wait", int'(bus.o_sel), 1);
      cyc(1); chk("dwell_tick1", int'(bus.o_sel), 2);
      cyc(8); chk("dwell_tick2", int'(bus.o_sel), 3);
      cyc(8); chk("dwell_wrap", int'(bus.o_sel), 0);
      // STEP event lands on the same edge as the next dwell tick.
      cyc(1);
      bus.i_buttons[0] = 1'b1;
      cyc(7); chk("step_on_tick", int'(bus.o_sel), 1);
      bus.i_buttons[0] = 1'b0;
      cyc(7); chk("dwell_cleared", int'(bus.o_sel), 1);
      cyc(1); chk("dwell_after_step", int'(bus.o_sel), 2);
      press(1, 8);
      chk("mode_live_again", int'(bus.o_mode), 0);
`else
      press(1, 8);
      chk("mode_live", int'(bus.o_mode), 0);
      chk("live_out_ch1", int'(bus.o_out), 'hDD);
      bus.i_channels[1] = 8'h66;
      trig();
      chk("live_trig_ignored", int'(bus.o_out), 'h99);
      press(1, 8);
      chk("mode_hold2", int'(bus.o_mode), 1);
      bus.i_channels[1] = 8'h77;
      cyc(2);
      chk("hold2_frozen", int'(bus.o_out), 'h99);
      trig();
      chk("hold2_trig", int'(bus.o_out), 'h88);
      press(1, 8);
      chk("mode_live2", int'(bus.o_mode), 0);
`endif

      sel_before  = int'(bus.o_sel);
      mode_before = int'(bus.o_mode);
      pulses = 0;
      bus.i_buttons = 2'b11;
      for (int i = 0; i < 30; i++) begin cyc(1); if (bus.o_reset) pulses++; end
      bus.i_buttons = 2'b00;
      for (int i = 0; i < 12; i++) begin cyc(1); if (bus.o_reset) pulses++; end
      chk("hold_long_pulses", pulses, 1);
      chk("hold_long_sel",  int'(bus.o_sel),  sel_before);
      chk("hold_long_mode", int'(bus.o_mode), mode_before);

      pulses = 0;
      bus.i_buttons = 2'b11;
      for (int i = 0; i < 10; i++) begin cyc(1); if (bus.o_reset) pulses++; end
      bus.i_buttons = 2'b00;
      for (int i = 0; i < 12; i++) begin cyc(1); if (bus.o_reset) pulses++; end
      chk("hold_short_pulses", pulses, 0);
      chk("hold_short_sel",  int'(bus.o_sel),  sel_before);
      chk("hold_short_mode", int'(bus.o_mode), mode_before);

      i_reset = 1'b1;
      cyc(2);
      chk("rst2_sel",  int'(bus.o_sel),  0);
      chk("rst2_mode", int'(bus.o_mode), 0);
      chk("rst2_out",  int'(bus.o_out),  'hFF);
      i_reset = 1'b0;

      // Reset lands before the STEP press qualifies; nothing must leak out afterwards.
      bus.i_buttons[0] = 1'b1;
      cyc(5);
      i_reset = 1'b1;
      cyc(1);
      bus.i_buttons[0] = 1'b0;
      cyc(1);
      i_reset = 1'b0;
      cyc(12);
      chk("mid_debounce_sel", int'(bus.o_sel), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
